data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 13 +
 rtl/data_sram_resp_lfsr8.sv | 19 +
 rtl/data_sram_resp.sv | 100 ++++++++++
 3 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data SRAM responder: FSM encodings and
// the random-stall LFSR seed/taps (used with DATA_SRAM_RAND_STALL_EN).
package data_sram_resp_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Galois right-shift mask for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_SEED = 8'h5A;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/data_sram_resp_lfsr8.sv
// 8-bit Galois LFSR driving random addr_ok stalls; only instantiated
// when DATA_SRAM_RAND_STALL_EN is defined.
module lfsr8
  import data_sram_resp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else begin
      q <= {1'b0, q[7:1]} ^ (q[0] ? LFSR_TAPS : 8'h00);
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Single-port data SRAM with addr_ok/data_ok handshake and fixed latency.
// Define DATA_SRAM_RAND_STALL_EN to add LFSR-driven random addr_ok stalls.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_WD = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int         DEPTH    = 1 << ADDR_WD;
  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  logic [1:0]         state;
  logic [1:0]         cnt;
  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_buf;
  logic [31:0]        rdata_q;
  logic               rd_pend;
  logic               stall;
  logic               accept;
  logic [ADDR_WD-1:0] idx;
  logic               unused_addr;

`ifdef DATA_SRAM_RAND_STALL_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign stall       = (lfsr[1:0] == 2'b00);
  assign unused_lfsr = ^lfsr[7:2];
`else
  assign stall = 1'b0;
`endif

  assign addr_ok     = (state != WAIT) && !stall;
  assign accept      = req && addr_ok;
  assign idx         = addr[ADDR_WD+1:2];
  assign unused_addr = ^{addr[31:ADDR_WD+2], addr[1:0]};
  assign data_ok     = (state == RESP);
  // Read word is visible during its response cycle, then held
  assign rdata       = (data_ok && rd_pend) ? rd_buf : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      rdata_q <= 32'h0;
      rd_pend <= 1'b0;
    end else begin
      if (data_ok && rd_pend) begin
        rdata_q <= rd_buf;
      end
      if (accept) begin
        rd_pend <= !wr;
        cnt     <= CNT_INIT;
        state   <= (CNT_INIT == 2'd0) ? RESP : WAIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 2'd1;
        if (cnt <= 2'd1) begin
          state <= RESP;
        end
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !wr) begin
      rd_buf <= mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
